// File: rtl/csr_access_unit_pkg.sv
// Shared types for the CSR access path: CSR op encoding and read-only address prefix.
package csr_access_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RW = 2'd0,
        CSR_OP_RS = 2'd1,
        CSR_OP_RC = 2'd2
    } csr_op_t;

    // CSRs whose two top address bits match this prefix are read-only.
    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write for CSR ops: new value, write intent, read-only violation.
// Encoding 3 is reserved and behaves as set-bits (RS).
module csr_rmw_alu
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old_data,
    input  logic [XLEN-1:0] src,
    input  logic            src_zero,
    input  logic [1:0]      addr_prefix,
    output logic [XLEN-1:0] new_data,
    output logic            will_write,
    output logic            illegal
);

    always_comb begin
        new_data = old_data | src;
        case (op)
            CSR_OP_RW: new_data = src;
            CSR_OP_RC: new_data = old_data & ~src;
            default:   new_data = old_data | src;
        endcase
    end

    // RW always writes (even a zero source); RS/RC with x0/uimm==0 are pure reads.
    assign will_write = (op == CSR_OP_RW) | ~src_zero;
    assign illegal    = will_write & (addr_prefix == CSR_RO_PREFIX);

endmodule

// File: rtl/csr_access_unit.sv
// CSR access front-end: S0 reads the CSR combinationally and accepts, S1 holds the old value
// and issues the RMW write on response handoff. One request per cycle, one cycle latency.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NW_WIDTH   = 2,
    parameter int UUID_WIDTH = 16,
    parameter int ADDR_BITS  = 12
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [UUID_WIDTH-1:0] req_uuid,
    input  logic [NW_WIDTH-1:0]   req_wid,
    input  logic [1:0]            req_op,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [XLEN-1:0]       req_src,
    input  logic                  req_src_zero,

    output logic                  csr_read_enable,
    output logic [UUID_WIDTH-1:0] csr_read_uuid,
    output logic [NW_WIDTH-1:0]   csr_read_wid,
    output logic [ADDR_BITS-1:0]  csr_read_addr,
    input  logic [XLEN-1:0]       csr_read_data_ro,
    input  logic [XLEN-1:0]       csr_read_data_rw,

    output logic                  csr_write_enable,
    output logic [UUID_WIDTH-1:0] csr_write_uuid,
    output logic [NW_WIDTH-1:0]   csr_write_wid,
    output logic [ADDR_BITS-1:0]  csr_write_addr,
    output logic [XLEN-1:0]       csr_write_data,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [UUID_WIDTH-1:0] rsp_uuid,
    output logic [NW_WIDTH-1:0]   rsp_wid,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  rsp_illegal
);

    logic                  s1_valid;
    logic [UUID_WIDTH-1:0] s1_uuid;
    logic [NW_WIDTH-1:0]   s1_wid;
    logic [ADDR_BITS-1:0]  s1_addr;
    logic [1:0]            s1_op;
    logic [XLEN-1:0]       s1_src;
    logic                  s1_src_zero;
    logic [XLEN-1:0]       s1_old;

    logic            accept;
    logic            handoff;
    logic            forward;
    logic [XLEN-1:0] old0;
    logic [XLEN-1:0] new_data;
    logic            will_write;
    logic            illegal;

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .op          (s1_op),
        .old_data    (s1_old),
        .src         (s1_src),
        .src_zero    (s1_src_zero),
        .addr_prefix (s1_addr[ADDR_BITS-1 -: 2]),
        .new_data    (new_data),
        .will_write  (will_write),
        .illegal     (illegal)
    );

    assign req_ready = ~s1_valid | rsp_ready;
    assign accept    = req_valid & req_ready;
    assign handoff   = s1_valid & rsp_ready;

    assign csr_read_enable = accept;
    assign csr_read_uuid   = req_uuid;
    assign csr_read_wid    = req_wid;
    assign csr_read_addr   = req_addr;

    // Reset gates the write combinationally so a dropped S1 entry never reaches the CSR block.
    assign csr_write_enable = handoff & will_write & ~illegal & ~reset;
    assign csr_write_uuid   = s1_uuid;
    assign csr_write_wid    = s1_wid;
    assign csr_write_addr   = s1_addr;
    assign csr_write_data   = new_data;

    // The CSR block only sees this cycle's write at the next edge, so a dependent read bypasses it.
    assign forward = csr_write_enable & accept & (req_wid == s1_wid) & (req_addr == s1_addr);
    assign old0    = forward ? new_data : (csr_read_data_ro | csr_read_data_rw);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (handoff) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_uuid     <= req_uuid;
            s1_wid      <= req_wid;
            s1_addr     <= req_addr;
            s1_op       <= req_op;
            s1_src      <= req_src;
            s1_src_zero <= req_src_zero;
            s1_old      <= old0;
        end
    end

    assign rsp_valid   = s1_valid;
    assign rsp_uuid    = s1_uuid;
    assign rsp_wid     = s1_wid;
    assign rsp_data    = s1_old;
    assign rsp_illegal = s1_valid & illegal;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a CSR data block model, a program-order reference model with
// per-cycle comparison, directed scenarios with literal expectations, then random traffic.
module tb_csr_access_unit;

    localparam logic [31:0] ROVAL = 32'hC0DE_0000;
    localparam logic [11:0] ADDRS [4] = '{12'h340, 12'h341, 12'hC00, 12'h305};

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        req_valid, req_ready;
    logic [15:0] req_uuid;
    logic [1:0]  req_wid, req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic        csr_read_enable;
    logic [15:0] csr_read_uuid;
    logic [1:0]  csr_read_wid;
    logic [11:0] csr_read_addr;
    logic [31:0] csr_read_data_ro, csr_read_data_rw;
    logic        csr_write_enable;
    logic [15:0] csr_write_uuid;
    logic [1:0]  csr_write_wid;
    logic [11:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_uuid;
    logic [1:0]  rsp_wid;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    always #5 clk = ~clk;

    csr_access_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_uuid         (req_uuid),
        .req_wid          (req_wid),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_src          (req_src),
        .req_src_zero     (req_src_zero),
        .csr_read_enable  (csr_read_enable),
        .csr_read_uuid    (csr_read_uuid),
        .csr_read_wid     (csr_read_wid),
        .csr_read_addr    (csr_read_addr),
        .csr_read_data_ro (csr_read_data_ro),
        .csr_read_data_rw (csr_read_data_rw),
        .csr_write_enable (csr_write_enable),
        .csr_write_uuid   (csr_write_uuid),
        .csr_write_wid    (csr_write_wid),
        .csr_write_addr   (csr_write_addr),
        .csr_write_data   (csr_write_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_uuid         (rsp_uuid),
        .rsp_wid          (rsp_wid),
        .rsp_data         (rsp_data),
        .rsp_illegal      (rsp_illegal)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int aidx(input logic [11:0] a);
        case (a)
            12'h341: return 1;
            12'hC00: return 2;
            12'h305: return 3;
            default: return 0;
        endcase
    endfunction

    // CSR data block: read-only CSRs return a fixed per-warp constant.
    logic [31:0] mem  [4][4];
    logic [31:0] arch [4][4];

    always @(posedge clk) begin
        if (init) begin
            for (int w = 0; w < 4; w++)
                for (int i = 0; i < 4; i++) mem[w][i] <= '0;
        end else if (csr_write_enable) begin
            mem[csr_write_wid][aidx(csr_write_addr)] <= csr_write_data;
        end
    end

    always_comb begin
        csr_read_data_ro = '0;
        csr_read_data_rw = '0;
        if (csr_read_addr[11:10] == 2'b11) csr_read_data_ro = ROVAL | 32'(csr_read_wid);
        else csr_read_data_rw = mem[csr_read_wid][aidx(csr_read_addr)];
    end

    // Reference model: instructions take effect in acceptance order on 'arch'.
    typedef struct {
        logic [15:0] uuid;
        logic [1:0]  wid;
        logic [11:0] addr;
        logic [31:0] old;
        logic        ill;
        logic        we;
        logic [31:0] nv;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        logic        we;
        logic [31:0] wdata;
    } log_t;

    exp_t exp_q[$];
    log_t log_q[$];

    always @(negedge clk) begin : compare
        exp_t e;
        log_t l;
        logic rdy, ww, ro;
        if (reset) begin
            check("write_in_reset", csr_write_enable, 0);
            exp_q.delete();
            arch = mem;
        end else begin
            rdy = (exp_q.size() == 0) || rsp_ready;
            check("rsp_valid", rsp_valid, exp_q.size() != 0);
            check("req_ready", req_ready, rdy);
            check("read_enable", csr_read_enable, req_valid && rdy);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("rsp_uuid", rsp_uuid, e.uuid);
                check("rsp_wid", rsp_wid, e.wid);
                check("rsp_data", rsp_data, e.old);
                check("rsp_illegal", rsp_illegal, e.ill);
                if (rsp_ready) begin
                    check("write_enable", csr_write_enable, e.we);
                    if (e.we) begin
                        check("write_data", csr_write_data, e.nv);
                        check("write_addr", csr_write_addr, e.addr);
                        check("write_wid", csr_write_wid, e.wid);
                        check("write_uuid", csr_write_uuid, e.uuid);
                    end
                    l.data = rsp_data; l.ill = rsp_illegal;
                    l.we = csr_write_enable; l.wdata = csr_write_data;
                    log_q.push_back(l);
                    void'(exp_q.pop_front());
                end else begin
                    check("write_while_stalled", csr_write_enable, 0);
                end
            end else begin
                check("write_while_empty", csr_write_enable, 0);
            end
            if (req_valid && rdy) begin
                check("read_addr", csr_read_addr, req_addr);
                check("read_wid", csr_read_wid, req_wid);
                check("read_uuid", csr_read_uuid, req_uuid);
                ro = (req_addr[11:10] == 2'b11);
                e.uuid = req_uuid; e.wid = req_wid; e.addr = req_addr;
                e.old  = ro ? (ROVAL | 32'(req_wid)) : arch[req_wid][aidx(req_addr)];
                ww     = (req_op == 2'd0) || !req_src_zero;
                e.ill  = ww && ro;
                e.we   = ww && !ro;
                case (req_op)
                    2'd0:    e.nv = req_src;
                    2'd2:    e.nv = e.old & ~req_src;
                    default: e.nv = e.old | req_src;
                endcase
                if (e.we) arch[req_wid][aidx(req_addr)] = e.nv;
                exp_q.push_back(e);
            end
        end
    end

    logic [15:0] uuid_ctr = 16'h0100;

    task automatic drive(input logic [1:0] op, input logic [1:0] w, input logic [11:0] a,
                         input logic [31:0] s, input logic z);
        req_valid = 1'b1; req_op = op; req_wid = w; req_addr = a;
        req_src = s; req_src_zero = z; req_uuid = uuid_ctr;
        uuid_ctr++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] w, input logic [11:0] a,
                         input logic [31:0] s, input logic z);
        bit ok;
        ok = 0;
        drive(op, w, a, s, z);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] data,
                             input logic ill, input logic we, input logic [31:0] wdata);
        if (idx >= log_q.size()) begin
            check({name, "_missing"}, log_q.size(), idx + 1);
        end else begin
            check({name, "_data"}, log_q[idx].data, data);
            check({name, "_ill"}, log_q[idx].ill, ill);
            check({name, "_we"}, log_q[idx].we, we);
            if (we) check({name, "_wdata"}, log_q[idx].wdata, wdata);
        end
    endtask

    initial begin
        logic [15:0] u1;
        init = 1'b1; reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_uuid = '0; req_wid = '0; req_op = '0; req_addr = '0; req_src = '0; req_src_zero = 1'b0;
        @(posedge clk); #1; init = 1'b0;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_write_enable", csr_write_enable, 0);
        check("reset_read_enable", csr_read_enable, 0);
        check("reset_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // RW returns the old value and writes the new one on handoff
        log_q.delete();
        issue(2'd0, 2'd0, 12'h340, 32'h0000_1234, 1'b0);
        issue(2'd0, 2'd0, 12'h340, 32'hDEAD_BEEF, 1'b0);
        idle(2);
        check_log("rw_init", 0, 32'h0, 0, 1, 32'h0000_1234);
        check_log("rw", 1, 32'h0000_1234, 0, 1, 32'hDEAD_BEEF);

        // Back-to-back dependent RS/RC on the same CSR rely on forwarding
        log_q.delete();
        issue(2'd0, 2'd1, 12'h341, 32'h0000_00F0, 1'b0);
        issue(2'd1, 2'd1, 12'h341, 32'h0000_000F, 1'b0);
        issue(2'd2, 2'd1, 12'h341, 32'h0000_003C, 1'b0);
        idle(2);
        check_log("fwd_rw", 0, 32'h0, 0, 1, 32'h0000_00F0);
        check_log("fwd_rs", 1, 32'h0000_00F0, 0, 1, 32'h0000_00FF);
        check_log("fwd_rc", 2, 32'h0000_00FF, 0, 1, 32'h0000_00C3);

        // RS with a zero source only reads
        log_q.delete();
        issue(2'd1, 2'd1, 12'h341, 32'h0, 1'b1);
        idle(2);
        check_log("rs_zero", 0, 32'h0000_00C3, 0, 0, 32'h0);

        // Read-only CSR: write attempt is illegal, pure read is not
        log_q.delete();
        issue(2'd0, 2'd0, 12'hC00, 32'h5, 1'b0);
        issue(2'd1, 2'd0, 12'hC00, 32'h0, 1'b1);
        idle(2);
        check_log("ro_rw", 0, ROVAL, 1, 0, 32'h0);
        check_log("ro_rs_zero", 1, ROVAL, 0, 0, 32'h0);

        // Backpressure: S1 holds, no write, no accept until released
        log_q.delete();
        rsp_ready = 1'b0;
        u1 = uuid_ctr;
        issue(2'd0, 2'd2, 12'h305, 32'h0000_00AA, 1'b0);
        drive(2'd0, 2'd2, 12'h305, 32'h0000_00BB, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_write", csr_write_enable, 0);
            check("bp_uuid", rsp_uuid, u1);
            check("bp_data", rsp_data, 0);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_write", csr_write_enable, 1);
        check("bp_release_wdata", csr_write_data, 32'h0000_00AA);
        check("bp_release_ready", req_ready, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        idle(2);
        check_log("bp_first", 0, 32'h0, 0, 1, 32'h0000_00AA);
        check_log("bp_second", 1, 32'h0000_00AA, 0, 1, 32'h0000_00BB);

        // Reset with a pending write and rsp_ready high drops it
        rsp_ready = 1'b0;
        issue(2'd0, 2'd3, 12'h340, 32'h0000_0077, 1'b0);
        rsp_ready = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("rst_mid_write", csr_write_enable, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        log_q.delete();
        issue(2'd1, 2'd3, 12'h340, 32'h0, 1'b1);
        idle(2);
        check_log("rst_no_write", 0, 32'h0, 0, 0, 32'h0);

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 199) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                logic z;
                logic [31:0] s;
                z = ($urandom_range(0, 3) == 0);
                s = z ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom);
                drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      ADDRS[$urandom_range(0, 3)], s, z);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0;
        idle(3);
        check("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
